// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Tracks in-flight conditional branches between fetch and execute. Fetch pushes
// {pc, predicted direction}; execute resolves the oldest entry in order. Each
// resolve trains the BHT one cycle later, and a mispredict raises a one-cycle
// flush with the corrected fetch PC and discards every younger (wrong-path) entry.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   if_branch/if_pc/if_pred_taken     push request from fetch
//   ex_resolve/ex_taken/ex_target     in-order resolve from execute
//   full                              queue holds DEPTH entries (from registered count)
//   bp_update/bp_taken/bp_pc          registered BHT training
//   flush/redirect_pc                 registered mispredict flush and corrected PC
//   branch_count/mispredict_count     saturating statistics
//   underflow_err                     sticky: resolve seen with an empty queue
module branch_resolve_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_branch,
    input  logic [31:0] if_pc,
    input  logic        if_pred_taken,
    input  logic        ex_resolve,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        full,
    output logic        bp_update,
    output logic        bp_taken,
    output logic [31:0] bp_pc,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count,
    output logic        underflow_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   pc_mem_d   [DEPTH];
    logic [DEPTH-1:0] pred_mem_q, pred_mem_d;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          bp_update_q, bp_update_d;
    logic          bp_taken_q, bp_taken_d;
    logic [31:0]   bp_pc_q, bp_pc_d;
    logic          flush_q, flush_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;
    logic [31:0]   branch_count_q, branch_count_d;
    logic [31:0]   mispredict_count_q, mispredict_count_d;
    logic          underflow_q, underflow_d;

    logic          empty;
    logic          valid_resolve;
    logic          mispredict;
    logic          push;
    logic [31:0]   head_pc;
    logic          head_pred;

    assign empty         = (count_q == '0);
    assign full          = (count_q == CW'(DEPTH));
    assign head_pc       = pc_mem_q[rd_ptr_q];
    assign head_pred     = pred_mem_q[rd_ptr_q];
    assign valid_resolve = ex_resolve && !empty;
    assign mispredict    = valid_resolve && (head_pred != ex_taken);
    // A mispredict makes any concurrent fetch wrong-path, so it is not queued.
    assign push          = if_branch && !full && !mispredict;

    always_comb begin
        pc_mem_d           = pc_mem_q;
        pred_mem_d         = pred_mem_q;
        wr_ptr_d           = wr_ptr_q;
        rd_ptr_d           = rd_ptr_q;
        count_d            = count_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        underflow_d        = underflow_q | (ex_resolve & empty);

        if (push) begin
            pc_mem_d[wr_ptr_q]   = if_pc;
            pred_mem_d[wr_ptr_q] = if_pred_taken;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end

        if (mispredict) begin
            // Drop every entry: read pointer catches up with the write pointer.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (valid_resolve) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(valid_resolve);
        end

        if (valid_resolve && branch_count_q != 32'hFFFF_FFFF) begin
            branch_count_d = branch_count_q + 32'd1;
        end
        if (mispredict && mispredict_count_q != 32'hFFFF_FFFF) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end

        bp_update_d   = valid_resolve;
        bp_taken_d    = valid_resolve & ex_taken;
        bp_pc_d       = valid_resolve ? head_pc : 32'd0;
        flush_d       = mispredict;
        redirect_pc_d = 32'd0;
        if (mispredict) begin
            redirect_pc_d = ex_taken ? ex_target : head_pc + 32'd4;
        end
    end

    // Entry storage needs no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        pred_mem_q <= pred_mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            count_q            <= '0;
            bp_update_q        <= 1'b0;
            bp_taken_q         <= 1'b0;
            bp_pc_q            <= 32'd0;
            flush_q            <= 1'b0;
            redirect_pc_q      <= 32'd0;
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
            underflow_q        <= 1'b0;
        end else begin
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            count_q            <= count_d;
            bp_update_q        <= bp_update_d;
            bp_taken_q         <= bp_taken_d;
            bp_pc_q            <= bp_pc_d;
            flush_q            <= flush_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            underflow_q        <= underflow_d;
        end
    end

    assign bp_update        = bp_update_q;
    assign bp_taken         = bp_taken_q;
    assign bp_pc            = bp_pc_q;
    assign flush            = flush_q;
    assign redirect_pc      = redirect_pc_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
    assign underflow_err    = underflow_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (DEPTH=4). Each step drives one cycle of
// inputs and queues the registered outputs expected after that edge; the entry is
// popped and compared once the edge has happened.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_branch;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_resolve;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        full;
    logic        bp_update;
    logic        bp_taken;
    logic [31:0] bp_pc;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
    logic        underflow_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        upd;
        logic        tkn;
        logic [31:0] pc;
        logic        fl;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];

    branch_resolve_unit #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_branch        (if_branch),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_resolve       (ex_resolve),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .full             (full),
        .bp_update        (bp_update),
        .bp_taken         (bp_taken),
        .bp_pc            (bp_pc),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .underflow_err    (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One cycle: drive inputs, queue expected registered outputs, clock, compare.
    task automatic cyc(input logic r, input logic br, input logic [31:0] pc, input logic pred,
                       input logic res, input logic tkn, input logic [31:0] tgt,
                       input logic e_upd, input logic e_tkn, input logic [31:0] e_pc,
                       input logic e_fl, input logic [31:0] e_rd, input string tag);
        exp_t e;
        rst = r; if_branch = br; if_pc = pc; if_pred_taken = pred;
        ex_resolve = res; ex_taken = tkn; ex_target = tgt;
        e.upd = e_upd; e.tkn = e_tkn; e.pc = e_pc; e.fl = e_fl; e.rd = e_rd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".bp_update"},   32'(bp_update),   32'(e.upd));
        chk({tag, ".bp_taken"},    32'(bp_taken),    32'(e.tkn));
        chk({tag, ".bp_pc"},       bp_pc,            e.pc);
        chk({tag, ".flush"},       32'(flush),       32'(e.fl));
        chk({tag, ".redirect_pc"}, redirect_pc,      e.rd);
    endtask

    task automatic push_b(input logic [31:0] pc, input logic pred, input string tag);
        cyc(1'b0, 1'b1, pc, pred, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, tag);
    endtask

    task automatic idle(input string tag);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, tag);
    endtask

    initial begin
        // Reset
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, "rst0");
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, "rst1");
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.branch_count", branch_count, 32'd0);
        chk("rst.mispredict_count", mispredict_count, 32'd0);
        chk("rst.underflow", 32'(underflow_err), 32'd0);

        // Correct taken prediction
        push_b(32'h100, 1'b1, "p100");
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h999,
            1'b1, 1'b1, 32'h100, 1'b0, 32'd0, "r100");
        chk("r100.branch_count", branch_count, 32'd1);
        chk("r100.mispredict_count", mispredict_count, 32'd0);

        // Predicted not-taken but taken; younger entries and a concurrent push dropped
        push_b(32'h200, 1'b0, "p200");
        push_b(32'h204, 1'b0, "p204");
        push_b(32'h208, 1'b1, "p208");
        cyc(1'b0, 1'b1, 32'h20C, 1'b1, 1'b1, 1'b1, 32'h400,
            1'b1, 1'b1, 32'h200, 1'b1, 32'h400, "r200");
        chk("r200.mispredict_count", mispredict_count, 32'd1);
        chk("r200.branch_count", branch_count, 32'd2);
        idle("r200.flush_one_cycle");

        // Predicted taken but not taken: redirect to fall-through
        push_b(32'h300, 1'b1, "p300");
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'hDEAD,
            1'b1, 1'b0, 32'h300, 1'b1, 32'h304, "r300");
        chk("r300.mispredict_count", mispredict_count, 32'd2);
        chk("r300.underflow", 32'(underflow_err), 32'd0);

        // Fill, drop fifth push, drain in order
        push_b(32'h500, 1'b1, "p500");
        push_b(32'h504, 1'b1, "p504");
        push_b(32'h508, 1'b1, "p508");
        chk("fill3.full", 32'(full), 32'd0);
        push_b(32'h50C, 1'b1, "p50C");
        chk("fill4.full", 32'(full), 32'd1);
        push_b(32'h510, 1'b1, "p510_dropped");
        chk("drop.full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0,
                1'b1, 1'b1, 32'h500 + 32'(4 * i), 1'b0, 32'd0, "drain5");
        end
        chk("drain5.full", 32'(full), 32'd0);

        // Wrapped pointers; full blocks push during pop; push+pop holds count
        for (int i = 0; i < 4; i++) begin
            push_b(32'h700 + 32'(4 * i), 1'b0, "p7xx");
        end
        chk("fill7.full", 32'(full), 32'd1);
        cyc(1'b0, 1'b1, 32'h710, 1'b0, 1'b1, 1'b0, 32'd0,
            1'b1, 1'b0, 32'h700, 1'b0, 32'd0, "r700_blocked_push");
        chk("r700.full", 32'(full), 32'd0);
        cyc(1'b0, 1'b1, 32'h714, 1'b0, 1'b1, 1'b0, 32'd0,
            1'b1, 1'b0, 32'h704, 1'b0, 32'd0, "r704_push714");
        chk("r704.full", 32'(full), 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0,
            1'b1, 1'b0, 32'h708, 1'b0, 32'd0, "r708");
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0,
            1'b1, 1'b0, 32'h70C, 1'b0, 32'd0, "r70C");
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0,
            1'b1, 1'b0, 32'h714, 1'b0, 32'd0, "r714");
        chk("r714.branch_count", branch_count, 32'd12);
        chk("r714.mispredict_count", mispredict_count, 32'd2);

        // Resolve on empty queue
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h123,
            1'b0, 1'b0, 32'd0, 1'b0, 32'd0, "uf");
        chk("uf.underflow", 32'(underflow_err), 32'd1);
        chk("uf.branch_count", branch_count, 32'd12);
        idle("uf.idle");
        chk("uf.sticky", 32'(underflow_err), 32'd1);

        // Reset beats a simultaneous mispredict and push
        push_b(32'h800, 1'b0, "p800");
        push_b(32'h804, 1'b0, "p804");
        push_b(32'h808, 1'b0, "p808");
        cyc(1'b1, 1'b1, 32'h80C, 1'b0, 1'b1, 1'b1, 32'h900,
            1'b0, 1'b0, 32'd0, 1'b0, 32'd0, "rst_mp");
        chk("rst_mp.full", 32'(full), 32'd0);
        chk("rst_mp.branch_count", branch_count, 32'd0);
        chk("rst_mp.mispredict_count", mispredict_count, 32'd0);
        chk("rst_mp.underflow", 32'(underflow_err), 32'd0);
        // Queue must be empty now: a resolve only raises underflow
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h900,
            1'b0, 1'b0, 32'd0, 1'b0, 32'd0, "rst_mp.empty");
        chk("rst_mp.empty_underflow", 32'(underflow_err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
